// File: rtl/mem_access_ctrl_pkg.sv
// Purpose: shared access-mode constants, FSM encoding and size helper for the MEM-stage load/store path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_mem_pkg;

    // Access modes, shared with the data RAM
    localparam logic [1:0] LOAD_WORD    = 2'b00;
    localparam logic [1:0] LOAD_HALF_S  = 2'b01;
    localparam logic [1:0] LOAD_HALF_U  = 2'b10;
    localparam logic [1:0] LOAD_ILLEGAL = 2'b11;

    // Sequencer states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Number of bytes moved for a given mode
    function automatic logic [2:0] access_size(input logic [1:0] mode);
        return (mode == LOAD_WORD) ? 3'd4 : 3'd2;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Purpose: EX/MEM-side request/response bundle of the load/store sequencer.
// Latency: n/a (wires only).
// Backpressure: req_ready/stall driven by the slave; master holds request until resp_valid.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        load_mode;
    logic [ADDR_W-1:0] address;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              resp_valid;
    logic              access_err;
    logic              stall;

    modport master (
        output req_valid, mem_read, mem_write, load_mode, address, write_data,
        input  req_ready, read_data, resp_valid, access_err, stall
    );

    modport slave (
        input  req_valid, mem_read, mem_write, load_mode, address, write_data,
        output req_ready, read_data, resp_valid, access_err, stall
    );
endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// Purpose: sign/zero-extend the assembled load bytes according to the access mode.
// Latency: combinational.
// Backpressure: none.
// Ports: raw = assembled bytes, mode = access mode, data = extended result.
module load_extend
    import mips_mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  mode,
    output logic [31:0] data
);
    always_comb begin
        data = 32'h0;
        case (mode)
            LOAD_WORD:   data = raw;
            LOAD_HALF_S: data = {{16{raw[15]}}, raw[15:0]};
            LOAD_HALF_U: data = {16'h0, raw[15:0]};
            default:     data = 32'h0;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Purpose: MEM-stage load/store sequencer moving one byte per cycle to/from a byte-wide RAM.
// Latency: accept->resp_valid: word load 6, half load 4, word store 5, half store 3, error 1.
// Backpressure: req_ready only in IDLE; stall high whenever not IDLE; one request in flight.
// Ports: clk/rst_n; pipe (slave side of mem_access_ctrl_if); ram_addr/ram_re/ram_we/ram_wdata/ram_rdata.
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_ctrl_if.slave  pipe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);
    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        mode_q;
    logic [31:0]       wdata_q;
    logic              load_q;
    logic              err_q;
    logic [1:0]        last_q;      // index of final byte (N-1)
    logic [1:0]        cnt_q;       // byte being issued
    logic              cap_vld_q;   // a read byte arrives this cycle
    logic [1:0]        cap_idx_q;   // which byte index is arriving
    logic [31:0]       data_q;
    logic [31:0]       read_data_q;

    logic        accept;
    logic        req_err;
    logic [1:0]  issue_pos;
    logic [1:0]  cap_pos;
    logic [31:0] assembled;
    logic [31:0] ext_data;

    assign accept = (state == IDLE) && pipe.req_valid && (pipe.mem_read || pipe.mem_write);

    assign req_err = (pipe.mem_read && pipe.mem_write)
                  || (pipe.load_mode == LOAD_ILLEGAL)
                  || ((pipe.load_mode == LOAD_WORD) && (pipe.address[1:0] != 2'b00))
                  || ((pipe.load_mode != LOAD_WORD) && pipe.address[0]);

    // Byte k lands at lane N-1-k when big-endian, lane k otherwise
    assign issue_pos = BIG_ENDIAN ? (last_q - cnt_q)     : cnt_q;
    assign cap_pos   = BIG_ENDIAN ? (last_q - cap_idx_q) : cap_idx_q;

    // Merge the byte arriving this cycle so DRAIN can register the complete word
    always_comb begin
        assembled = data_q;
        if (cap_vld_q) begin
            assembled[{cap_pos, 3'b000} +: 8] = ram_rdata;
        end
    end

    load_extend u_load_extend (
        .raw  (assembled),
        .mode (mode_q),
        .data (ext_data)
    );

    assign ram_re    = (state == ISSUE) && load_q;
    assign ram_we    = (state == ISSUE) && !load_q;
    assign ram_addr  = (state == ISSUE) ? (addr_q + ADDR_W'(cnt_q)) : '0;
    assign ram_wdata = ram_we ? wdata_q[{issue_pos, 3'b000} +: 8] : 8'h00;

    assign pipe.req_ready  = (state == IDLE);
    assign pipe.stall      = (state != IDLE);
    assign pipe.resp_valid = (state == RESP);
    assign pipe.access_err = (state == RESP) && err_q;
    assign pipe.read_data  = read_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            mode_q      <= LOAD_WORD;
            wdata_q     <= 32'h0;
            load_q      <= 1'b0;
            err_q       <= 1'b0;
            last_q      <= 2'd0;
            cnt_q       <= 2'd0;
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= 2'd0;
            data_q      <= 32'h0;
            read_data_q <= 32'h0;
        end else begin
            cap_vld_q <= ram_re;
            cap_idx_q <= cnt_q;
            if (accept) begin
                data_q <= 32'h0;
            end else if (cap_vld_q) begin
                data_q <= assembled;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= pipe.address;
                        mode_q  <= pipe.load_mode;
                        wdata_q <= pipe.write_data;
                        load_q  <= pipe.mem_read && !pipe.mem_write;
                        err_q   <= req_err;
                        last_q  <= 2'(access_size(pipe.load_mode) - 3'd1);
                        cnt_q   <= 2'd0;
                        if (req_err) begin
                            read_data_q <= 32'h0;
                            state       <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == last_q) begin
                        state <= load_q ? DRAIN : RESP;
                    end
                end
                DRAIN: begin
                    read_data_q <= ext_data;
                    state       <= RESP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose: self-checking bench for mem_access_ctrl with a byte RAM model and response scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_ctrl;
    import mips_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(32)) pipe ();

    logic [31:0] ram_addr;
    logic        ram_re;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    mem_access_ctrl #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pipe      (pipe),
        .ram_addr  (ram_addr),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Byte RAM model: read data one cycle after ram_re
    logic [7:0] ram [0:255];

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            'h10: return 8'h12;
            'h11: return 8'h34;
            'h12: return 8'h56;
            'h13: return 8'h78;
            'h20: return 8'hF0;
            'h21: return 8'h0F;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_byte(i);
            ram_rdata <= 8'h00;
        end else begin
            if (ram_re) ram_rdata <= ram[ram_addr[7:0]];
            if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected strobe stream of the current request
    logic        mon_en = 1'b1;
    logic [31:0] mon_base = 32'h0;
    logic [31:0] mon_wdata = 32'h0;
    logic        mon_load = 1'b0;
    int          mon_nb = 0;
    int          strobe_k = 0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (ram_re && ram_we) chk("re_we_overlap", 32'(ram_we), 32'h0);
            if (ram_re || ram_we) begin
                chk("strobe_kind", 32'(ram_re), 32'(mon_load));
                chk("ram_addr", ram_addr, mon_base + 32'(strobe_k));
                if (ram_we)
                    chk("ram_wdata", 32'(ram_wdata),
                        (mon_wdata >> (8 * (mon_nb - 1 - strobe_k))) & 32'hFF);
                strobe_k++;
            end
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
        int          nb;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] data;
        int          lat;
        int          nb;
    } vec_t;
    vec_t vecs[14];

    task automatic setup_req(input logic rd, input logic wr, input logic [1:0] mode,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic err, input logic [31:0] data, input int lat, input int nb);
        exp_t e;
        e.err = err; e.data = data; e.lat = lat; e.nb = nb;
        sb.push_back(e);
        mon_base = addr; mon_wdata = wdata; mon_nb = nb; mon_load = rd & ~wr; strobe_k = 0;
        pipe.mem_read = rd; pipe.mem_write = wr; pipe.load_mode = mode;
        pipe.address = addr; pipe.write_data = wdata; pipe.req_valid = 1'b1;
    endtask

    // Called at the sample point of cycle 1 after the accept edge; returns in the RESP cycle
    task automatic wait_resp(input string name);
        int   cyc;
        logic stall_ok;
        exp_t e;
        cyc = 1;
        stall_ok = 1'b1;
        while (!pipe.resp_valid && cyc < 20) begin
            if (!pipe.stall) stall_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (!pipe.stall) stall_ok = 1'b0;
        chk({name, "_resp_valid"}, 32'(pipe.resp_valid), 32'h1);
        if (sb.size() == 0) begin
            chk({name, "_sb_size"}, 32'h0, 32'h1);
        end else begin
            e = sb.pop_front();
            chk({name, "_latency"}, 32'(cyc), 32'(e.lat));
            chk({name, "_access_err"}, 32'(pipe.access_err), 32'(e.err));
            chk({name, "_read_data"}, pipe.read_data, e.data);
            chk({name, "_strobes"}, 32'(strobe_k), 32'(e.nb));
        end
        chk({name, "_stall_held"}, 32'(stall_ok), 32'h1);
    endtask

    task automatic run_req(input vec_t v, input string name);
        setup_req(v.rd, v.wr, v.mode, v.addr, v.wdata, v.err, v.data, v.lat, v.nb);
        chk({name, "_req_ready"}, 32'(pipe.req_ready), 32'h1);
        @(posedge clk); #1;
        pipe.req_valid = 1'b0;
        wait_resp(name);
        @(posedge clk); #1;
        chk({name, "_pulse_end"}, 32'(pipe.resp_valid), 32'h0);
        chk({name, "_idle_ready"}, 32'(pipe.req_ready), 32'h1);
    endtask

    initial begin
        logic ok;
        vec_t v;

        //          rd    wr    mode   addr      wdata         err   data          lat nb
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 32'h10, 32'h0,        1'b0, 32'h12345678, 6, 4};
        vecs[1]  = '{1'b1, 1'b0, 2'b01, 32'h20, 32'h0,        1'b0, 32'hFFFFF00F, 4, 2};
        vecs[2]  = '{1'b1, 1'b0, 2'b10, 32'h20, 32'h0,        1'b0, 32'h0000F00F, 4, 2};
        vecs[3]  = '{1'b0, 1'b1, 2'b00, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0000F00F, 5, 4};
        vecs[4]  = '{1'b1, 1'b0, 2'b00, 32'h40, 32'h0,        1'b0, 32'hDEADBEEF, 6, 4};
        vecs[5]  = '{1'b0, 1'b1, 2'b01, 32'h50, 32'h1234ABCD, 1'b0, 32'hDEADBEEF, 3, 2};
        vecs[6]  = '{1'b1, 1'b0, 2'b10, 32'h50, 32'h0,        1'b0, 32'h0000ABCD, 4, 2};
        vecs[7]  = '{1'b1, 1'b0, 2'b00, 32'h41, 32'h0,        1'b1, 32'h0,        1, 0};
        vecs[8]  = '{1'b0, 1'b1, 2'b01, 32'h33, 32'h5555,     1'b1, 32'h0,        1, 0};
        vecs[9]  = '{1'b1, 1'b0, 2'b11, 32'h20, 32'h0,        1'b1, 32'h0,        1, 0};
        vecs[10] = '{1'b1, 1'b1, 2'b00, 32'h10, 32'h0,        1'b1, 32'h0,        1, 0};
        vecs[11] = '{1'b1, 1'b0, 2'b01, 32'h12, 32'h0,        1'b0, 32'h00005678, 4, 2};
        vecs[12] = '{1'b0, 1'b1, 2'b10, 32'h52, 32'hFFFF8001, 1'b0, 32'h00005678, 3, 2};
        vecs[13] = '{1'b1, 1'b0, 2'b01, 32'h52, 32'h0,        1'b0, 32'hFFFF8001, 4, 2};

        pipe.req_valid = 1'b0; pipe.mem_read = 1'b0; pipe.mem_write = 1'b0;
        pipe.load_mode = 2'b00; pipe.address = 32'h0; pipe.write_data = 32'h0;

        // Reset values
        #2;
        chk("rst_req_ready", 32'(pipe.req_ready), 32'h1);
        chk("rst_stall", 32'(pipe.stall), 32'h0);
        chk("rst_resp_valid", 32'(pipe.resp_valid), 32'h0);
        chk("rst_access_err", 32'(pipe.access_err), 32'h0);
        chk("rst_read_data", pipe.read_data, 32'h0);
        chk("rst_ram_strobes", {30'h0, ram_re, ram_we}, 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Valid with neither read nor write must be ignored
        pipe.req_valid = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (pipe.stall || pipe.resp_valid || !pipe.req_ready) ok = 1'b0;
        end
        pipe.req_valid = 1'b0;
        chk("nop_ignored", 32'(ok), 32'h1);

        for (int i = 0; i < 14; i++) run_req(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset during cycle 2 of a word store
        mon_en = 1'b0;
        pipe.mem_read = 1'b0; pipe.mem_write = 1'b1; pipe.load_mode = LOAD_WORD;
        pipe.address = 32'h60; pipe.write_data = 32'hCAFEBABE; pipe.req_valid = 1'b1;
        @(posedge clk); #1;
        pipe.req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(pipe.req_ready), 32'h1);
        chk("midrst_stall", 32'(pipe.stall), 32'h0);
        chk("midrst_ram_we", 32'(ram_we), 32'h0);
        chk("midrst_read_data", pipe.read_data, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        ok = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (pipe.resp_valid || pipe.stall) ok = 1'b0;
        end
        chk("midrst_no_resp", 32'(ok), 32'h1);
        mon_en = 1'b1;
        v = vecs[0];
        run_req(v, "post_rst");

        // Back-to-back with req_valid held: one IDLE cycle between the two responses
        setup_req(1'b1, 1'b0, LOAD_WORD, 32'h10, 32'h0, 1'b0, 32'h12345678, 6, 4);
        @(posedge clk); #1;
        wait_resp("b2b_first");
        chk("b2b_resp_not_ready", 32'(pipe.req_ready), 32'h0);
        setup_req(1'b1, 1'b0, LOAD_HALF_S, 32'h20, 32'h0, 1'b0, 32'hFFFFF00F, 4, 2);
        @(posedge clk); #1;
        chk("b2b_gap_ready", 32'(pipe.req_ready), 32'h1);
        @(posedge clk); #1;
        pipe.req_valid = 1'b0;
        chk("b2b_second_accepted", 32'(pipe.stall), 32'h1);
        wait_resp("b2b_second");
        @(posedge clk); #1;
        chk("b2b_pulse_end", 32'(pipe.resp_valid), 32'h0);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
